cb_seq_mult: RTL and testbench

Parametrised sequential shift-add multiplier built around one row of WIDTH carry-save cells of the existing cb type (partial-product AND plus full adder). It replaces the combinational cb array with one row reused over WIDTH cycles. It adds a start/busy/done handshake, selectable signed (two's complement) or unsigned operation, and a held result register. It sits between the operand-source logic and the EDC result path.

---
 rtl/cb_seq_mult_if.sv | 23 ++
 rtl/cb_seq_mult.sv | 110 +++++++++++
 tb/tb_cb_seq_mult.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/cb_seq_mult_if.sv
// Handshake and operand/result bundle for the sequential multiplier.
// The master drives requests and operands, and the slave returns status and the product.
interface cb_seq_mult_if #(
  parameter int WIDTH = 4
);
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/cb_seq_mult.sv
// Sequential shift-add multiplier. One row of cb cells (partial-product AND
// plus full adder) is reused for WIDTH cycles. The block supports unsigned or
// two's-complement operands. In signed mode the last row subtracts the
// multiplicand, because the multiplier MSB has negative weight.
module cb_seq_mult #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  cb_seq_mult_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               mode_q;
  logic [WIDTH-1:0]   acc_hi_q;
  logic [WIDTH-1:0]   acc_lo_q;
  logic [CW-1:0]      count_q;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] product_q;

  logic               negate;
  logic [WIDTH-1:0]   pp;
  logic [WIDTH:0]     x_ext;
  logic [WIDTH:0]     y_ext;
  logic [WIDTH:0]     carry;
  logic [WIDTH:0]     sum_d;

  // One carry-save row: select the operands, then ripple through the full adders (WIDTH+1 bits wide).
  always_comb begin
    negate = mode_q & (count_q == LAST) & b_q[0];
    pp     = a_q & {WIDTH{b_q[0]}};
    x_ext  = mode_q ? {acc_hi_q[WIDTH-1], acc_hi_q} : {1'b0, acc_hi_q};
    if (negate) begin
      y_ext = ~{a_q[WIDTH-1], a_q};
    end else if (mode_q) begin
      y_ext = {pp[WIDTH-1], pp};
    end else begin
      y_ext = {1'b0, pp};
    end
    carry    = '0;
    sum_d    = '0;
    carry[0] = negate;
    for (int i = 0; i < WIDTH; i++) begin
      sum_d[i]   = x_ext[i] ^ y_ext[i] ^ carry[i];
      carry[i+1] = (x_ext[i] & y_ext[i]) | (x_ext[i] & carry[i]) | (y_ext[i] & carry[i]);
    end
    sum_d[WIDTH] = x_ext[WIDTH] ^ y_ext[WIDTH] ^ carry[WIDTH];
  end

  // Control FSM and datapath registers. FINISH publishes the product and can also accept the next start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= 1'b0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, FINISH: begin
          if (state_q == FINISH) begin
            product_q <= {acc_hi_q, acc_lo_q};
            done_q    <= 1'b1;
          end
          if (bus.start) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            mode_q   <= bus.signed_mode;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end else begin
            state_q  <= IDLE;
          end
        end
        RUN: begin
          acc_hi_q <= sum_d[WIDTH:1];
          acc_lo_q <= {sum_d[0], acc_lo_q[WIDTH-1:1]};
          b_q      <= b_q >> 1;
          if (count_q == LAST) begin
            busy_q  <= 1'b0;
            state_q <= FINISH;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
endmodule

// File: tb/tb_cb_seq_mult.sv
// Directed bench for cb_seq_mult. It uses a WIDTH=4 instance for the vector table and handshake corners.
// A WIDTH=8 instance covers the wider latency and extreme products.
module tb_cb_seq_mult;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  cb_seq_mult_if #(.WIDTH(4)) if4 ();
  cb_seq_mult_if #(.WIDTH(8)) if8 ();

  cb_seq_mult #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  cb_seq_mult #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  typedef struct {
    logic       sm;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for done on the 4-bit DUT and count the busy samples seen on the way.
  task automatic wait_done4(output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    do begin
      tick();
      n++;
      if (if4.busy) nbusy++;
    end while (!if4.done && n < 20);
  endtask

  task automatic op4(input string nm, input logic sm, input logic [3:0] a,
                     input logic [3:0] b, input logic [7:0] exp);
    int n, nb;
    if4.start = 1'b1; if4.signed_mode = sm; if4.a = a; if4.b = b;
    tick();
    if4.start = 1'b0;
    chk({nm, " busy_after_start"}, 32'(if4.busy), 32'd1);
    wait_done4(n, nb);
    chk({nm, " latency"}, 32'(n), 32'd5);
    chk({nm, " busy_cycles"}, 32'(nb + 1), 32'd4);
    chk({nm, " product"}, 32'(if4.product), 32'(exp));
    tick();
    chk({nm, " done_one_cycle"}, 32'(if4.done), 32'd0);
    tick(); tick();
    chk({nm, " product_held"}, 32'(if4.product), 32'(exp));
  endtask

  task automatic op8(input string nm, input logic sm, input logic [7:0] a,
                     input logic [7:0] b, input logic [15:0] exp);
    int n;
    if8.start = 1'b1; if8.signed_mode = sm; if8.a = a; if8.b = b;
    tick();
    if8.start = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!if8.done && n < 30);
    chk({nm, " latency"}, 32'(n), 32'd9);
    chk({nm, " product"}, 32'(if8.product), 32'(exp));
  endtask

  initial begin
    int n, nb, ndone, first;
    vecs[0]  = '{1'b0, 4'hF, 4'hF, 8'hE1};
    vecs[1]  = '{1'b1, 4'h8, 4'h8, 8'h40};
    vecs[2]  = '{1'b0, 4'h8, 4'h8, 8'h40};
    vecs[3]  = '{1'b0, 4'h7, 4'h8, 8'h38};
    vecs[4]  = '{1'b1, 4'h7, 4'h8, 8'hC8};
    vecs[5]  = '{1'b1, 4'hF, 4'hF, 8'h01};
    vecs[6]  = '{1'b0, 4'h0, 4'hF, 8'h00};
    vecs[7]  = '{1'b1, 4'h0, 4'h8, 8'h00};
    vecs[8]  = '{1'b1, 4'h8, 4'h7, 8'hC8};
    vecs[9]  = '{1'b1, 4'h3, 4'hE, 8'hFA};
    vecs[10] = '{1'b0, 4'hC, 4'hD, 8'h9C};
    vecs[11] = '{1'b1, 4'h8, 4'hF, 8'h08};
    vecs[12] = '{1'b1, 4'h7, 4'h7, 8'h31};

    if4.start = 1'b0; if4.signed_mode = 1'b0; if4.a = '0; if4.b = '0;
    if8.start = 1'b0; if8.signed_mode = 1'b0; if8.a = '0; if8.b = '0;

    rst_n = 1'b0;
    tick(); tick();
    chk("reset busy4", 32'(if4.busy), 32'd0);
    chk("reset done4", 32'(if4.done), 32'd0);
    chk("reset product4", 32'(if4.product), 32'd0);
    chk("reset busy8", 32'(if8.busy), 32'd0);
    chk("reset done8", 32'(if8.done), 32'd0);
    chk("reset product8", 32'(if8.product), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      op4($sformatf("vec%0d", i), vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    // A start issued while busy, together with operand and mode changes, is ignored.
    if4.start = 1'b1; if4.signed_mode = 1'b0; if4.a = 4'd3; if4.b = 4'd5;
    tick();
    if4.start = 1'b0;
    tick();
    if4.start = 1'b1; if4.signed_mode = 1'b1; if4.a = 4'd9; if4.b = 4'd9;
    tick();
    if4.start = 1'b0;
    ndone = 0; first = 0;
    for (int c = 3; c <= 14; c++) begin
      if (if4.done) begin
        ndone++;
        if (first == 0) first = c - 1;
        chk("ignore product", 32'(if4.product), 32'h0F);
      end
      tick();
    end
    chk("ignore done_count", 32'(ndone), 32'd1);
    chk("ignore latency", 32'(first), 32'd5);

    // Reset in the middle of an operation discards it.
    if4.start = 1'b1; if4.signed_mode = 1'b0; if4.a = 4'hF; if4.b = 4'hF;
    tick();
    if4.start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst busy", 32'(if4.busy), 32'd0);
    chk("midrst done", 32'(if4.done), 32'd0);
    chk("midrst product", 32'(if4.product), 32'd0);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (if4.done) ndone++;
    end
    chk("midrst no_done", 32'(ndone), 32'd0);
    op4("after_rst", 1'b0, 4'd2, 4'd3, 8'h06);

    // Back-to-back operations: a new start arrives on the done cycle.
    if4.start = 1'b1; if4.signed_mode = 1'b0; if4.a = 4'd5; if4.b = 4'd6;
    tick();
    if4.start = 1'b0;
    wait_done4(n, nb);
    chk("b2b first latency", 32'(n), 32'd5);
    chk("b2b first product", 32'(if4.product), 32'h1E);
    if4.start = 1'b1; if4.a = 4'd4; if4.b = 4'd4;
    tick();
    if4.start = 1'b0;
    chk("b2b accepted busy", 32'(if4.busy), 32'd1);
    chk("b2b done dropped", 32'(if4.done), 32'd0);
    wait_done4(n, nb);
    chk("b2b second latency", 32'(n), 32'd5);
    chk("b2b second product", 32'(if4.product), 32'h10);

    // Wider instance.
    op8("w8 unsigned max", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
    op8("w8 signed min", 1'b1, 8'h80, 8'h80, 16'h4000);
    op8("w8 signed mix", 1'b1, 8'h7F, 8'h80, 16'hC080);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
